// File: rtl/m_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module   : m_dmem_resp
// Brief    : Word memory with a fixed-latency valid/ready request/response port.
//            Define DMEM_BE_EN to add the w_req_be byte-enable port.
// Revision : 1.0
// ============================================================================
module m_dmem_resp #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_req_valid,
    output logic        w_req_ready,
    input  logic        w_req_we,
    input  logic [31:0] w_req_adr,
    input  logic [31:0] w_req_wd,
`ifdef DMEM_BE_EN
    input  logic [3:0]  w_req_be,
`endif
    output logic        w_rsp_valid,
    input  logic        w_rsp_ready,
    output logic [31:0] w_rsp_rd,
    output logic        w_rsp_err
);

    localparam int          c_ADDR_W    = $clog2(DEPTH);
    localparam logic [32:0] c_LIMIT     = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  c_WAIT_LOAD = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;

    logic              r_we;
    logic [31:0]       r_adr;
    logic [31:0]       r_wd;
    logic [3:0]        r_be;
    logic [3:0]        w_be_in;

    logic [31:0]       r_mem [DEPTH] = '{default: '0};

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_cur_we;
    logic [31:0]       w_cur_adr;
    logic [31:0]       w_cur_wd;
    logic [3:0]        w_cur_be;
    logic              w_err;
    logic [c_ADDR_W-1:0] w_idx;

`ifdef DMEM_BE_EN
    assign w_be_in = w_req_be;
`else
    assign w_be_in = 4'hF;
`endif

    assign w_req_ready = (r_state == S_IDLE);
    assign w_rsp_valid = (r_state == S_RESP);
    assign w_accept    = w_req_valid && (r_state == S_IDLE);

    // With LATENCY==1 the response is formed on the accept edge itself, so
    // the live request inputs are used instead of the captured copy.
    assign w_cur_we  = (r_state == S_IDLE) ? w_req_we  : r_we;
    assign w_cur_adr = (r_state == S_IDLE) ? w_req_adr : r_adr;
    assign w_cur_wd  = (r_state == S_IDLE) ? w_req_wd  : r_wd;
    assign w_cur_be  = (r_state == S_IDLE) ? w_be_in   : r_be;

    assign w_err = (w_cur_adr[1:0] != 2'b00) || ({1'b0, w_cur_adr} >= c_LIMIT);
    assign w_idx = w_cur_adr[c_ADDR_W+1:2];

    assign w_enter_resp = ((r_state == S_IDLE) && w_accept && (LATENCY == 1))
                       || ((r_state == S_WAIT) && (r_cnt == 4'd0));

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (LATENCY > 1) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_WAIT_LOAD;
                    end else begin
                        w_state_nxt = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (w_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_we  <= 1'b0;
            r_adr <= 32'd0;
            r_wd  <= 32'd0;
            r_be  <= 4'd0;
        end else if (w_accept) begin
            r_we  <= w_req_we;
            r_adr <= w_req_adr;
            r_wd  <= w_req_wd;
            r_be  <= w_be_in;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_rsp_rd  <= 32'd0;
            w_rsp_err <= 1'b0;
        end else if (w_enter_resp) begin
            w_rsp_rd  <= w_err ? 32'd0 : r_mem[w_idx];
            w_rsp_err <= w_err;
        end else if ((r_state == S_RESP) && w_rsp_ready) begin
            w_rsp_rd  <= 32'd0;
            w_rsp_err <= 1'b0;
        end
    end

    // Storage survives reset; the reset gate keeps an in-flight write from landing.
    always_ff @(posedge w_clk) begin
        if (w_rst_n && w_enter_resp && w_cur_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_cur_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_cur_wd[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_dmem_resp.sv
`default_nettype none
// Testbench for m_dmem_resp (DEPTH=64, LATENCY=2): directed cases plus random
// transactions checked against a word-array reference model.
module tb_m_dmem_resp;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_adr;
    logic [31:0] req_wd;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rd;
    logic        rsp_err;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    m_dmem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .w_clk       (clk),
        .w_rst_n     (rst_n),
        .w_req_valid (req_valid),
        .w_req_ready (req_ready),
        .w_req_we    (req_we),
        .w_req_adr   (req_adr),
        .w_req_wd    (req_wd),
`ifdef DMEM_BE_EN
        .w_req_be    (req_be),
`endif
        .w_rsp_valid (rsp_valid),
        .w_rsp_ready (rsp_ready),
        .w_rsp_rd    (rsp_rd),
        .w_rsp_err   (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction, started and finished on a falling edge.
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [3:0] be, input int hold);
        logic        e_err;
        logic [31:0] e_rd;
        logic [3:0]  e_be;
        logic [31:0] word;
        int          edges;
        e_be = be;
`ifndef DMEM_BE_EN
        e_be = 4'hF;
`endif
        e_err = (adr % 4 != 0) || (adr >= 4 * DEPTH);
        e_rd  = e_err ? 32'd0 : model[adr / 4];
        if (we && !e_err) begin
            word = model[adr / 4];
            for (int b = 0; b < 4; b++)
                if (e_be[b]) word[8*b +: 8] = wd[8*b +: 8];
            model[adr / 4] = word;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_adr = adr; req_wd = wd; req_be = be;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_adr = $urandom; req_wd = $urandom; req_be = 4'($urandom);
        edges = 1;
        while (!rsp_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        chk("rsp_latency", 32'(edges), 32'(LAT));
        chk("rsp_rd", rsp_rd, e_rd);
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rd", rsp_rd, e_rd);
            chk("hold_err", 32'(rsp_err), 32'(e_err));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_valid", 32'(rsp_valid), 32'd0);
        chk("post_rd", rsp_rd, 32'd0);
        chk("post_err", 32'(rsp_err), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = 32'd0;
        req_wd = 32'd0; req_be = 4'hF; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rd", rsp_rd, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write then read back
        txn(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 0);
        txn(1'b0, 32'h20, 32'h0, 4'hF, 0);
        // Response stalled for five cycles
        txn(1'b0, 32'h20, 32'h0, 4'hF, 5);
        // Out-of-range write, then read of word 0
        txn(1'b1, 32'h100, 32'h12345678, 4'hF, 1);
        txn(1'b0, 32'h0, 32'h0, 4'hF, 0);
        // Misaligned read must not disturb storage
        txn(1'b0, 32'h22, 32'h0, 4'hF, 0);
        txn(1'b0, 32'h20, 32'h0, 4'hF, 0);
`ifdef DMEM_BE_EN
        txn(1'b1, 32'h10, 32'h11223344, 4'hF, 0);
        txn(1'b1, 32'h10, 32'hAABBCCDD, 4'b0110, 0);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 0);
        chk("be_merge_model", model[4], 32'h11BBCC44);
        txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 0);
`endif

        // Reset during WAIT of a write: the write is dropped
        req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h30; req_wd = 32'h5; req_be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        txn(1'b0, 32'h30, 32'h0, 4'hF, 0);

        // Reset while a response is pending drops it without a handshake
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("resp_pending", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("resprst_valid", 32'(rsp_valid), 32'd0);
        chk("resprst_rd", rsp_rd, 32'd0);
        chk("resprst_req_ready", 32'(req_ready), 32'd1);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Random traffic against the reference model
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 3))
                0, 1:    a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
                2:       a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
                default: a = 32'(4 * DEPTH) + ($urandom & 32'h00FF_FFFC);
            endcase
            txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
